// File: rtl/mac_result_reader_pkg.sv
// Shared types and index helpers for the MAC result reader and its siblings.
package mac_result_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Column-major flat layout used by the MAC and bias producers.
  function automatic int flat_idx(input int r, input int c, input int rows);
    return c * rows + r;
  endfunction

  function automatic int safe_clog2(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/mac_result_reader_lane_select.sv
// Combinational mux: picks LANES consecutive elements of one row from the captured matrix.
module mac_lane_select
  import mac_result_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 4,
  parameter int COLS       = 8,
  parameter int LANES      = 4,
  parameter int ROW_W      = 2,
  parameter int GRP_W      = 1
) (
  input  logic [DATA_WIDTH*ROWS*COLS-1:0] cap_i,
  input  logic [ROW_W-1:0]                row_i,
  input  logic [GRP_W-1:0]                grp_i,
  output logic [DATA_WIDTH*LANES-1:0]     lanes_o
);

  always_comb begin
    lanes_o = '0;
    for (int k = 0; k < LANES; k++) begin
      lanes_o[k*DATA_WIDTH +: DATA_WIDTH] =
        cap_i[flat_idx(int'(row_i), int'(grp_i) * LANES + k, ROWS)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

// File: rtl/mac_result_reader.sv
// Captures one flat MAC result matrix on start and streams it row-major, LANES elements per beat.
//   state     | meaning
//   ST_IDLE   | waiting for start; capture register holds the last matrix
//   ST_STREAM | presenting beats on out_valid/out_ready
//   ST_DONE   | one-cycle done pulse after the final handshake
module mac_result_reader
  import mac_result_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 4,
  parameter int COLS       = 8,
  parameter int LANES      = 4
) (
  input  logic                                   clk_p,
  input  logic                                   rst_n,
  input  logic                                   start,
  input  logic [DATA_WIDTH*ROWS*COLS-1:0]        mac_matrix,
  input  logic                                   flush,
  output logic                                   busy,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [DATA_WIDTH*LANES-1:0]            out_data,
  output logic [safe_clog2(ROWS)-1:0]            out_row,
  output logic [safe_clog2(COLS/LANES)-1:0]      out_colgrp,
  output logic                                   out_last,
  output logic                                   done
);

  localparam int NGRP  = COLS / LANES;
  localparam int ROW_W = safe_clog2(ROWS);
  localparam int GRP_W = safe_clog2(NGRP);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(NGRP - 1);

  state_e                          state_q, state_d;
  logic [ROW_W-1:0]                row_q, row_d;
  logic [GRP_W-1:0]                grp_q, grp_d;
  logic [DATA_WIDTH*ROWS*COLS-1:0] cap_q;
  logic                            cap_load;
  logic [DATA_WIDTH*LANES-1:0]     sel_data;

  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      grp_q   <= '0;
      cap_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      grp_q   <= grp_d;
      if (cap_load) cap_q <= mac_matrix;
    end
  end

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    grp_d    = grp_q;
    cap_load = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_STREAM;
          row_d    = '0;
          grp_d    = '0;
          cap_load = 1'b1;
        end
      end
      ST_STREAM: begin
        // Flush outranks the final handshake so an aborted transfer never signals done.
        if (flush) begin
          state_d = ST_IDLE;
          row_d   = '0;
          grp_d   = '0;
        end else if (out_ready) begin
          if (grp_q == GRP_LAST) begin
            grp_d = '0;
            if (row_q == ROW_LAST) begin
              row_d   = '0;
              state_d = ST_DONE;
            end else begin
              row_d = row_q + ROW_W'(1);
            end
          end else begin
            grp_d = grp_q + GRP_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        row_d   = '0;
        grp_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        row_d   = '0;
        grp_d   = '0;
      end
    endcase
  end

  mac_lane_select #(
    .DATA_WIDTH (DATA_WIDTH),
    .ROWS       (ROWS),
    .COLS       (COLS),
    .LANES      (LANES),
    .ROW_W      (ROW_W),
    .GRP_W      (GRP_W)
  ) u_lane_select (
    .cap_i   (cap_q),
    .row_i   (row_q),
    .grp_i   (grp_q),
    .lanes_o (sel_data)
  );

  assign busy       = (state_q != ST_IDLE);
  assign out_valid  = (state_q == ST_STREAM);
  assign done       = (state_q == ST_DONE);
  assign out_row    = row_q;
  assign out_colgrp = grp_q;
  assign out_last   = out_valid && (row_q == ROW_LAST) && (grp_q == GRP_LAST);
  assign out_data   = out_valid ? sel_data : '0;

endmodule

// File: tb/tb_mac_result_reader.sv
// Directed bench for mac_result_reader: beat order, backpressure, capture isolation, flush, signs, reset.
module tb_mac_result_reader;

  localparam int DW = 8;
  localparam int R  = 4;
  localparam int C  = 8;
  localparam int L  = 4;

  logic              clk_p = 1'b0;
  logic              rst_n;
  logic              start;
  logic [DW*R*C-1:0] mac_matrix;
  logic              flush;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic [DW*L-1:0]   out_data;
  logic [1:0]        out_row;
  logic [0:0]        out_colgrp;
  logic              out_last;
  logic              done;

  mac_result_reader #(
    .DATA_WIDTH (DW),
    .ROWS       (R),
    .COLS       (C),
    .LANES      (L)
  ) dut (
    .clk_p      (clk_p),
    .rst_n      (rst_n),
    .start      (start),
    .mac_matrix (mac_matrix),
    .flush      (flush),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_row    (out_row),
    .out_colgrp (out_colgrp),
    .out_last   (out_last),
    .done       (done)
  );

  always #5 clk_p = ~clk_p;

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic [1:0]  row;
    logic [0:0]  grp;
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t      tbl[8];
  logic [7:0] el[4][8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic fill_std();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        el[r][c] = 8'(r * 16 + c);
  endtask

  function automatic logic [DW*R*C-1:0] pack_el();
    logic [DW*R*C-1:0] m;
    m = '0;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        m[(c*R + r)*DW +: DW] = el[r][c];
    return m;
  endfunction

  // Caller raises start at a negedge; cycles counts from the start cycle to the done cycle inclusive.
  task automatic run_transfer(input bit bp, input bit disturb, output int cycles);
    int         beat;
    int         vcnt;
    int         cyc;
    bit         seen;
    bit         stalled;
    logic [35:0] held;
    bit         pat[4];
    pat     = '{1'b1, 1'b0, 1'b0, 1'b1};
    beat    = 0;
    vcnt    = 0;
    cyc     = 0;
    seen    = 1'b0;
    stalled = 1'b0;
    held    = '0;
    while (!seen && cyc < 100) begin
      @(negedge clk_p);
      cyc++;
      start = 1'b0;
      if (disturb && cyc == 3) begin
        mac_matrix = {32{8'h7F}};
        start      = 1'b1;
      end
      if (done) begin
        seen = 1'b1;
        chk("beats_before_done", 64'(beat), 64'd8);
        chk("valid_low_in_done", 64'(out_valid), 64'd0);
        if (disturb) start = 1'b1;
      end else if (out_valid) begin
        if (stalled)
          chk($sformatf("hold_beat%0d", beat), 64'({out_data, out_row, out_colgrp, out_last}), 64'(held));
        out_ready = bp ? pat[vcnt % 4] : 1'b1;
        vcnt++;
        if (out_ready) begin
          if (beat < 8) begin
            chk($sformatf("beat%0d_data", beat), 64'(out_data),   64'(tbl[beat].data));
            chk($sformatf("beat%0d_row", beat),  64'(out_row),    64'(tbl[beat].row));
            chk($sformatf("beat%0d_grp", beat),  64'(out_colgrp), 64'(tbl[beat].grp));
            chk($sformatf("beat%0d_last", beat), 64'(out_last),   64'(tbl[beat].last));
          end else begin
            chk("extra_beat", 64'(beat), 64'd7);
          end
          beat++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held    = {out_data, out_row, out_colgrp, out_last};
        end
      end
    end
    if (!seen) chk("done_timeout", 64'd0, 64'd1);
    cycles = cyc + 1;
    @(negedge clk_p);
    start     = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc;
    bit  found;
    tbl[0] = '{2'd0, 1'd0, 32'h03020100, 1'b0};
    tbl[1] = '{2'd0, 1'd1, 32'h07060504, 1'b0};
    tbl[2] = '{2'd1, 1'd0, 32'h13121110, 1'b0};
    tbl[3] = '{2'd1, 1'd1, 32'h17161514, 1'b0};
    tbl[4] = '{2'd2, 1'd0, 32'h23222120, 1'b0};
    tbl[5] = '{2'd2, 1'd1, 32'h27262524, 1'b0};
    tbl[6] = '{2'd3, 1'd0, 32'h33323130, 1'b0};
    tbl[7] = '{2'd3, 1'd1, 32'h37363534, 1'b1};

    rst_n     = 1'b0;
    start     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    fill_std();
    mac_matrix = pack_el();
    repeat (2) @(negedge clk_p);
    rst_n = 1'b1;
    @(negedge clk_p);
    chk("rst_busy",   64'(busy),       64'd0);
    chk("rst_valid",  64'(out_valid),  64'd0);
    chk("rst_last",   64'(out_last),   64'd0);
    chk("rst_done",   64'(done),       64'd0);
    chk("rst_data",   64'(out_data),   64'd0);
    chk("rst_row",    64'(out_row),    64'd0);
    chk("rst_colgrp", 64'(out_colgrp), 64'd0);

    // Full-rate transfer
    start = 1'b1; out_ready = 1'b1;
    run_transfer(1'b0, 1'b0, cyc);
    chk("start_to_done_cycles", 64'(cyc), 64'd10);

    // Backpressure 1,0,0,1
    start = 1'b1;
    run_transfer(1'b1, 1'b0, cyc);

    // Bus changes and start pulses while busy (including the done cycle)
    start = 1'b1;
    run_transfer(1'b0, 1'b1, cyc);
    chk("busy_start_ignored_busy",  64'(busy),      64'd0);
    chk("busy_start_ignored_valid", 64'(out_valid), 64'd0);
    repeat (2) @(negedge clk_p);
    chk("no_second_transfer", 64'(out_valid), 64'd0);
    fill_std();
    mac_matrix = pack_el();

    // Flush at beat 3, then restart with a signed matrix
    start = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk_p);
      start = 1'b0;
    end
    chk("flush_at_row", 64'(out_row),    64'd1);
    chk("flush_at_grp", 64'(out_colgrp), 64'd1);
    flush = 1'b1;
    @(negedge clk_p);
    flush = 1'b0;
    chk("flush_valid",  64'(out_valid),  64'd0);
    chk("flush_done",   64'(done),       64'd0);
    chk("flush_busy",   64'(busy),       64'd0);
    chk("flush_row",    64'(out_row),    64'd0);
    chk("flush_colgrp", 64'(out_colgrp), 64'd0);
    fill_std();
    el[0][0] = 8'h80;
    el[3][7] = 8'hFF;
    mac_matrix = pack_el();
    start = 1'b1;
    @(negedge clk_p);
    start = 1'b0;
    chk("signed_first_valid", 64'(out_valid), 64'd1);
    chk("signed_first_row",   64'(out_row),   64'd0);
    chk("signed_first_data",  64'(out_data),  64'h03020180);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk_p);
      if (out_last) begin
        found = 1'b1;
        chk("signed_last_data", 64'(out_data),   64'hFF363534);
        chk("signed_last_row",  64'(out_row),    64'd3);
        chk("signed_last_grp",  64'(out_colgrp), 64'd1);
      end
    end
    if (!found) chk("signed_last_timeout", 64'd0, 64'd1);
    @(negedge clk_p);
    chk("signed_done", 64'(done), 64'd1);
    @(negedge clk_p);

    // Flush coinciding with the final handshake
    fill_std();
    mac_matrix = pack_el();
    start = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk_p);
      start = 1'b0;
      if (out_last) begin
        found = 1'b1;
        flush = 1'b1;
      end
    end
    if (!found) chk("flush_last_timeout", 64'd0, 64'd1);
    @(negedge clk_p);
    flush = 1'b0;
    chk("flush_last_done",  64'(done),      64'd0);
    chk("flush_last_busy",  64'(busy),      64'd0);
    chk("flush_last_valid", 64'(out_valid), 64'd0);

    // Asynchronous reset during beat 2
    start = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk_p);
      start = 1'b0;
    end
    chk("pre_reset_row", 64'(out_row),    64'd1);
    chk("pre_reset_grp", 64'(out_colgrp), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_busy",  64'(busy),      64'd0);
    chk("async_rst_done",  64'(done),      64'd0);
    chk("async_rst_data",  64'(out_data),  64'd0);
    @(negedge clk_p);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_p);
    chk("post_reset_idle_busy",  64'(busy),      64'd0);
    chk("post_reset_idle_valid", 64'(out_valid), 64'd0);
    start = 1'b1;
    @(negedge clk_p);
    start = 1'b0;
    chk("post_reset_restart_data", 64'(out_data), 64'h03020100);
    repeat (12) @(negedge clk_p);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mac_result_reader.md
Name: mac_result_reader

Overview:
- Consumer side of the flat MAC output bus: captures one complete flat result matrix (mac_matrix layout) on a start pulse.
- Streams the matrix out row-major, LANES elements per beat, over a valid/ready interface to downstream stages (activation, requant, store).
- Converts the combinational wide-bus domain into a sequential, back-pressurable stream.

Parameters:
- DATA_WIDTH, 8, bits per signed element
- ROWS, 4, result rows (OUTPUT_SHAPE_1)
- COLS, 8, result columns (OUTPUT_SHAPE_2); must be a multiple of LANES
- LANES, 4, elements per output beat

Ports:
- clk_p  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  capture request; accepted only when busy=0
- mac_matrix  in  DATA_WIDTH*ROWS*COLS  flat result; element (r,c) at index c*ROWS+r, bits [(idx+1)*DATA_WIDTH-1 : idx*DATA_WIDTH]
- flush  in  1  synchronous abort of the current transfer
- busy  out  1  high from the cycle after start is accepted until return to IDLE
- out_valid  out  1  beat valid
- out_ready  in  1  downstream ready
- out_data  out  DATA_WIDTH*LANES  lane k = element (out_row, out_colgrp*LANES+k), lane 0 in LSBs
- out_row  out  clog2(ROWS) (min 1)  row of current beat
- out_colgrp  out  clog2(COLS/LANES) (min 1)  column group of current beat
- out_last  out  1  high on the final beat (last row, last group)
- done  out  1  one-cycle pulse after the final handshake

Behaviour:
- Reset: state IDLE; busy, out_valid, out_last, done = 0; out_data, out_row, out_colgrp = 0; capture register cleared.
- FSM states: IDLE, STREAM, DONE.
- IDLE:
  - start=1 copies mac_matrix into the capture register, clears the row/group counters and moves to STREAM.
  - Later changes on mac_matrix have no effect on the transfer.
- STREAM:
  - out_valid=1 from the first cycle after the start edge, so start-to-first-valid latency is 1 cycle.
  - Handshake = out_valid & out_ready. The group counter increments on each handshake; at COLS/LANES-1 it wraps to 0 and the row counter increments.
  - While out_valid=1 and out_ready=0, out_data, out_row, out_colgrp and out_last hold stable.
  - out_data is taken combinationally from the capture register and counters, or registered; either is acceptable, but it must be valid in the same cycle as out_valid.
  - A handshake with out_last=1 moves to DONE and drops out_valid the next cycle.
- DONE: done=1 for exactly one cycle, then return to IDLE with busy=0.
- start while busy=1, including in the DONE cycle: ignored, no capture. The earliest accepted restart is the cycle after done.
- flush=1 in STREAM or DONE: return to IDLE next cycle, out_valid=0, no done pulse, counters cleared.
- flush together with a final handshake: flush wins and done is not pulsed. flush in IDLE has no effect.
- start and flush together in IDLE: start is honoured.
- Asynchronous reset mid-stream: all outputs return to reset values immediately. Nothing is resumed.
- Total beats per matrix = ROWS*COLS/LANES. With out_ready tied high the transfer takes beats+2 cycles from start to done.
- No arithmetic on the data: elements pass through bit-exact, sign preserved.

Decomposition:
- Shared package holds:
  - state encoding enum (IDLE/STREAM/DONE);
  - a localparam function computing flat index c*ROWS+r, reused by the MAC and bias producers;
  - a safe clog2 helper returning a minimum of 1.
- One natural sub-module, mac_lane_select: a combinational mux picking LANES elements from the capture register given row and group. This keeps the FSM/counter logic separate and testable.

Test Plan:
- Layout and order. ROWS=4, COLS=8, LANES=4, element (r,c)=r*16+c, start, out_ready=1 -> 8 beats in row-major order.
  - Beat 0 lanes = 0x00,0x01,0x02,0x03; beat 1 = 0x04..0x07; beat 2 = 0x10..0x13.
  - out_last only on beat 7; done on the cycle after beat 7; start-to-done = 10 cycles.
- Backpressure. out_ready toggles 1,0,0,1 repeating -> every beat held stable while ready=0, no beats lost or duplicated, sequence identical to the first test.
- Capture isolation and busy start. Change mac_matrix to all 0x7F and pulse start during STREAM -> streamed data is still the original matrix, and no second transfer occurs.
- Flush. Assert flush at beat 3 with out_ready=1 -> out_valid=0 next cycle, no done. A new start one cycle later streams beat 0 of the new matrix.
- Signed values. Elements -128 (0x80) and -1 (0xFF) at (0,0) and (3,7) -> appear bit-exact in lane 0 of the first beat and lane 3 of the last beat.
- Reset. rst_n low mid-beat 2 -> out_valid, busy and done go to 0 asynchronously. After release the block stays idle until start.
